writeback_queue: RTL and testbench
==================================

// Module: writeback_queue
// PURPOSE
//  Producer/driver side of the register file write port. Buffers completed
//  writeback results {wsel, wdat} from the pipeline in a small in-order queue.
//  Drains one entry per enabled cycle onto the register file write port.
//  Gives two read ports a bypass lookup, so still-queued values are visible
//  before they are committed. Sits between the WB stage and register_file_if.
// PARAMETERS
//  DEPTH  4  queue entries; power of two, >=2
//  AW     5  register select width (32 architectural registers)
//  DW     32 data width (word_t)
// PORTS
//  CLK         in   1      single clock, all state on posedge
//  RST         in   1      reset: synchronous, active-high
//  push_valid  in   1      WB stage presents a result
//  push_ready  out  1      queue can accept; push occurs when valid&&ready
//  push_sel    in   AW     destination register
//  push_dat    in   DW     result data
//  drain_en    in   1      write port free this cycle (0 = port stalled)
//  rf_wen      out  1      register file write enable
//  rf_wsel     out  AW     register file write select
//  rf_wdat     out  DW     register file write data
//  byp_sel1/2  in   AW     read selects being looked up
//  byp_hit1/2  out  1      a queued entry matches the select
//  byp_dat1/2  out  DW     data of the youngest matching entry, else 0
//  count       out  $clog2(DEPTH)+1  valid entries held
//  empty       out  1      count==0
// BEHAVIOUR
//  Reset: all entries invalid, head/tail/count=0. Outputs: push_ready=1,
//   rf_wen=0, rf_wsel=0, rf_wdat=0, byp_hit*=0, byp_dat*=0, count=0, empty=1.
//   RST mid-operation discards all queued writes. Nothing is written back.
//  Circular buffer: head/tail wrap modulo DEPTH. count holds full vs empty.
//  push_ready = (count<DEPTH) || (rf_wen). A pop in the same cycle frees a
//   slot, so a full queue with drain accepts a push (count unchanged).
//  push_sel==0: accepted (handshake completes) but not stored. r0 is never written.
//  Drain: rf_wen = !empty && drain_en. rf_wsel/rf_wdat = head entry,
//   combinational. Pop at the edge when rf_wen=1. When empty, rf_wsel/rf_wdat = 0.
//  Write latency: an entry pushed into an empty queue drives rf_wen the next
//   cycle (earliest). Order of writes equals order of pushes.
//  Simultaneous push+pop: count unchanged, both pointers advance.
//  Bypass: combinational search over valid entries, including the head
//   being drained this cycle. Youngest (closest to tail) match wins.
//   sel==0 never hits. A push in the same cycle is not visible until the next cycle.
// CONFIGURATION
//  `WBQ_COALESCE_EN defined: a push whose push_sel matches a valid entry
//   overwrites that entry's data in place. No allocation, count unchanged,
//   push_ready=1 even when full. Exception: the match is the head and it is
//   popping this cycle, which allocates normally. Invariant: at most one
//   entry per register.
//  Not defined: every nonzero push allocates a new entry, and duplicates are allowed.
// STRUCTURE
//  cpu_types_pkg: reuse word_t and regbits_t. Add
//   typedef struct packed {logic v; regbits_t sel; word_t dat;} wbq_entry_t.
//  Sub-module wbq_match: combinational youngest-match priority search,
//   (entries, head, count, sel) -> (hit, dat). Instantiated twice for
//   bypass, plus once for coalescing when enabled.
// TESTING
//  1 Reset: assert RST 2 cycles -> rf_wen=0, empty=1, count=0, push_ready=1.
//  2 Order: drain_en=0, push r3=11,r4=22,r5=33 then drain_en=1 ->
//    writes r3,r4,r5 on 3 consecutive cycles, then empty=1.
//  3 Full/wrap: drain_en=0, push 4 entries -> push_ready=0. Raise drain_en
//    with push r7=0x77 -> accepted same cycle, count stays 4. Drain all ->
//    r7 written last, pointers wrapped.
//  4 Bypass: queue r9=1 then r9=2, byp_sel1=9 -> hit1=1, dat1=2.
//    byp_sel2=0 -> hit2=0, dat2=0.
//  5 r0: push sel=0 dat=0xDEAD -> handshake completes, count unchanged, no rf_wen.
//  6 Coalesce (macro on): drain_en=0, push r6=5 then r6=9 -> count=1,
//    drain writes r6=9 once. Macro off -> count=2, writes 5 then 9.
//  Also: RST asserted with 3 entries queued -> next cycle empty=1, no writes.

Source files
------------

// File: rtl/writeback_queue_pkg.sv
// Shared types for the writeback queue: register select, data word and queue entry.
package writeback_queue_pkg;

  localparam int unsigned Aw = 5;
  localparam int unsigned Dw = 32;

  typedef logic [Dw-1:0] word_t;
  typedef logic [Aw-1:0] regbits_t;

  typedef struct packed {
    logic     v;
    regbits_t sel;
    word_t    dat;
  } wbq_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Push handshake from the WB stage plus the register file write port.
interface writeback_queue_if;
  import writeback_queue_pkg::*;

  logic     push_valid;
  logic     push_ready;
  regbits_t push_sel;
  word_t    push_dat;
  logic     drain_en;
  logic     rf_wen;
  regbits_t rf_wsel;
  word_t    rf_wdat;

  modport master (
    output push_valid, push_sel, push_dat, drain_en,
    input  push_ready, rf_wen, rf_wsel, rf_wdat
  );

  modport slave (
    input  push_valid, push_sel, push_dat, drain_en,
    output push_ready, rf_wen, rf_wsel, rf_wdat
  );

endinterface

// File: rtl/writeback_queue_match.sv
// Youngest-match search over the valid region [head, head+count) of the queue.
module wbq_match
  import writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  wbq_entry_t [DEPTH-1:0] entries_i,
  input  logic [PtrW-1:0]        head_i,
  input  logic [PtrW:0]          count_i,
  input  regbits_t               sel_i,
  output logic                   hit_o,
  output word_t                  dat_o,
  output logic [PtrW-1:0]        idx_o
);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit_o = 1'b0;
    dat_o = '0;
    idx_o = '0;
    idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_i + PtrW'(i);
      if (((PtrW+1)'(i) < count_i) && entries_i[idx].v &&
          (entries_i[idx].sel == sel_i) && (sel_i != '0)) begin
        hit_o = 1'b1;
        dat_o = entries_i[idx].dat;
        idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue driving the register file write port, with two bypass lookups.
// Optional build macro: WBQ_COALESCE_EN merges a push into an existing entry for the same register.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                CLK,
  input  logic                RST,
  writeback_queue_if.slave    wb,
  input  regbits_t            byp_sel1,
  input  regbits_t            byp_sel2,
  output logic                byp_hit1,
  output logic                byp_hit2,
  output word_t               byp_dat1,
  output word_t               byp_dat2,
  output logic [CntW-1:0]     count,
  output logic                empty
);

  wbq_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PtrW-1:0]        head_q, head_d;
  logic [PtrW-1:0]        tail_q, tail_d;
  logic [CntW-1:0]        count_q, count_d;

  logic       empty_w;
  logic       full_w;
  logic       pop;
  logic       fire;
  logic       alloc;
  logic       upd;
  logic       co_hit;
  logic       co_take;
  logic [PtrW-1:0] co_idx;
  wbq_entry_t head_ent;

  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == CntW'(DEPTH));
  // Reset suppresses the write so a discarded entry never reaches the register file.
  assign pop      = !empty_w && wb.drain_en && !RST;
  assign head_ent = ent_q[head_q];

  assign wb.rf_wen  = pop;
  assign wb.rf_wsel = empty_w ? '0 : head_ent.sel;
  assign wb.rf_wdat = empty_w ? '0 : head_ent.dat;

`ifdef WBQ_COALESCE_EN
  word_t co_dat_unused;

  wbq_match #(.DEPTH(DEPTH)) u_match_co (
    .entries_i (ent_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .sel_i     (wb.push_sel),
    .hit_o     (co_hit),
    .dat_o     (co_dat_unused),
    .idx_o     (co_idx)
  );

  // A match on the head that is leaving this cycle must allocate a fresh entry.
  assign co_take = co_hit && !(pop && (co_idx == head_q));
`else
  assign co_hit  = 1'b0;
  assign co_idx  = '0;
  assign co_take = co_hit;
`endif

  assign wb.push_ready = !full_w || pop || co_take;
  assign fire          = wb.push_valid && wb.push_ready;
  assign alloc         = fire && (wb.push_sel != '0) && !co_take;
  assign upd           = fire && co_take;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CntW'(alloc) - CntW'(pop);
    if (pop) begin
      ent_d[head_q].v = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (upd) begin
      ent_d[co_idx].dat = wb.push_dat;
    end
    if (alloc) begin
      ent_d[tail_q] = '{v: 1'b1, sel: wb.push_sel, dat: wb.push_dat};
      tail_d        = tail_q + PtrW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  wbq_match #(.DEPTH(DEPTH)) u_match_byp1 (
    .entries_i (ent_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .sel_i     (byp_sel1),
    .hit_o     (byp_hit1),
    .dat_o     (byp_dat1),
    .idx_o     ()
  );

  wbq_match #(.DEPTH(DEPTH)) u_match_byp2 (
    .entries_i (ent_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .sel_i     (byp_sel2),
    .hit_o     (byp_hit2),
    .dat_o     (byp_dat2),
    .idx_o     ()
  );

  assign count = count_q;
  assign empty = empty_w;

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue; honours WBQ_COALESCE_EN when defined.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  logic     CLK = 1'b0;
  logic     RST = 1'b1;
  regbits_t byp_sel1 = '0;
  regbits_t byp_sel2 = '0;
  logic     byp_hit1, byp_hit2;
  word_t    byp_dat1, byp_dat2;
  logic [2:0] count;
  logic     empty;

  writeback_queue_if wb_if ();

  writeback_queue #(.DEPTH(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .wb       (wb_if),
    .byp_sel1 (byp_sel1),
    .byp_sel2 (byp_sel2),
    .byp_hit1 (byp_hit1),
    .byp_hit2 (byp_hit2),
    .byp_dat1 (byp_dat1),
    .byp_dat2 (byp_dat2),
    .count    (count),
    .empty    (empty)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         passed = 0;
  int         n_writes = 0;
  regbits_t   last_sel = '0;
  wbq_entry_t model_q[$];

  // Write-port monitor: every write must match the oldest expected entry.
  always @(negedge CLK) begin
    if (wb_if.rf_wen === 1'b1) begin
      wbq_entry_t exp_e;
      n_writes++;
      last_sel = wb_if.rf_wsel;
      checks++;
      if (model_q.size() == 0) begin
        $display("FAIL unexpected_write got sel=%0d dat=%h want no write",
                 wb_if.rf_wsel, wb_if.rf_wdat);
      end else begin
        exp_e = model_q.pop_front();
        if (wb_if.rf_wsel !== exp_e.sel || wb_if.rf_wdat !== exp_e.dat)
          $display("FAIL write_data got sel=%0d dat=%h want sel=%0d dat=%h",
                   wb_if.rf_wsel, wb_if.rf_wdat, exp_e.sel, exp_e.dat);
        else passed++;
      end
    end
  end

  task automatic model_push(input regbits_t sel, input word_t dat);
    bit done = 0;
`ifdef WBQ_COALESCE_EN
    for (int j = 0; j < model_q.size(); j++) begin
      if (model_q[j].sel == sel) begin
        model_q[j].dat = dat;
        done = 1;
      end
    end
`endif
    if (!done) model_q.push_back('{v: 1'b1, sel: sel, dat: dat});
  endtask

  // One clock of stimulus; acceptance and write enable sampled mid-cycle.
  task automatic drive_cycle(input logic v, input regbits_t sel, input word_t dat,
                             input logic drain, output logic acc, output logic wen);
    wb_if.push_valid = v;
    wb_if.push_sel   = sel;
    wb_if.push_dat   = dat;
    wb_if.drain_en   = drain;
    @(negedge CLK);
    acc = v && wb_if.push_ready;
    wen = wb_if.rf_wen;
    #1;
    if (acc && sel != '0) model_push(sel, dat);
    @(posedge CLK);
    #1;
    wb_if.push_valid = 1'b0;
  endtask

  task automatic drain_all(input int budget);
    logic acc, wen;
    for (int k = 0; k < budget && empty !== 1'b1; k++) drive_cycle(0, '0, '0, 1, acc, wen);
    checks++;
    if (empty !== 1'b1) $display("FAIL drain_timeout got empty=%b want 1", empty);
    else passed++;
  endtask

  task automatic test_reset();
    logic acc, wen;
    RST = 1'b1;
    drive_cycle(0, '0, '0, 0, acc, wen);
    drive_cycle(0, '0, '0, 0, acc, wen);
    RST = 1'b0;
    model_q.delete();
    @(negedge CLK);
    checks++;
    if ({wb_if.rf_wen, empty, count, wb_if.push_ready} !== {1'b0, 1'b1, 3'd0, 1'b1})
      $display("FAIL reset_state got wen=%b empty=%b count=%0d ready=%b want 0 1 0 1",
               wb_if.rf_wen, empty, count, wb_if.push_ready);
    else passed++;
    checks++;
    if ({wb_if.rf_wsel, wb_if.rf_wdat, byp_hit1, byp_dat1} !== '0)
      $display("FAIL reset_outputs got wsel=%0d wdat=%h hit1=%b dat1=%h want all 0",
               wb_if.rf_wsel, wb_if.rf_wdat, byp_hit1, byp_dat1);
    else passed++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_order();
    logic acc, wen;
    int   w0;
    drive_cycle(1, 5'd3, 32'd11, 0, acc, wen);
    drive_cycle(1, 5'd4, 32'd22, 0, acc, wen);
    drive_cycle(1, 5'd5, 32'd33, 0, acc, wen);
    w0 = n_writes;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(0, '0, '0, 1, acc, wen);
      checks++;
      if (wen !== 1'b1) $display("FAIL order_wen cycle %0d got %b want 1", k, wen);
      else passed++;
    end
    @(negedge CLK);
    checks++;
    if (empty !== 1'b1 || (n_writes - w0) != 3)
      $display("FAIL order_done got empty=%b writes=%0d want 1 3", empty, n_writes - w0);
    else passed++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_full_wrap();
    logic acc, wen;
    int   w0 = n_writes;
    for (int k = 1; k <= 4; k++) drive_cycle(1, regbits_t'(k), 32'h100 + k, 0, acc, wen);
    @(negedge CLK);
    checks++;
    if (wb_if.push_ready !== 1'b0 || count !== 3'd4)
      $display("FAIL full_state got ready=%b count=%0d want 0 4", wb_if.push_ready, count);
    else passed++;
    @(posedge CLK);
    #1;
    drive_cycle(1, 5'd7, 32'h77, 1, acc, wen);
    checks++;
    if (acc !== 1'b1) $display("FAIL full_push_drain got accepted=%b want 1", acc);
    else passed++;
    wb_if.drain_en = 1'b0;
    @(negedge CLK);
    checks++;
    if (count !== 3'd4) $display("FAIL full_count got %0d want 4", count);
    else passed++;
    @(posedge CLK);
    #1;
    drain_all(12);
    checks++;
    if (last_sel !== 5'd7 || (n_writes - w0) != 5)
      $display("FAIL wrap_last got sel=%0d writes=%0d want 7 5", last_sel, n_writes - w0);
    else passed++;
  endtask

  task automatic test_bypass();
    logic acc, wen;
    logic [2:0] exp_cnt;
    drive_cycle(1, 5'd9, 32'd1, 0, acc, wen);
    drive_cycle(1, 5'd9, 32'd2, 0, acc, wen);
    byp_sel1 = 5'd9;
    byp_sel2 = 5'd0;
    @(negedge CLK);
    checks++;
    if (byp_hit1 !== 1'b1 || byp_dat1 !== 32'd2)
      $display("FAIL bypass_youngest got hit=%b dat=%0d want 1 2", byp_hit1, byp_dat1);
    else passed++;
    checks++;
    if (byp_hit2 !== 1'b0 || byp_dat2 !== 32'd0)
      $display("FAIL bypass_r0 got hit=%b dat=%0d want 0 0", byp_hit2, byp_dat2);
    else passed++;
    @(posedge CLK);
    #1;
    // A push in flight must not show up in the same cycle's lookup.
    byp_sel2 = 5'd10;
    wb_if.push_valid = 1'b1;
    wb_if.push_sel   = 5'd10;
    wb_if.push_dat   = 32'd5;
    @(negedge CLK);
    checks++;
    if (byp_hit2 !== 1'b0) $display("FAIL bypass_same_cycle got hit=%b want 0", byp_hit2);
    else passed++;
    #1;
    model_push(5'd10, 32'd5);
    @(posedge CLK);
    #1;
    wb_if.push_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (byp_hit2 !== 1'b1 || byp_dat2 !== 32'd5)
      $display("FAIL bypass_next_cycle got hit=%b dat=%0d want 1 5", byp_hit2, byp_dat2);
    else passed++;
`ifdef WBQ_COALESCE_EN
    exp_cnt = 3'd2;
`else
    exp_cnt = 3'd3;
`endif
    checks++;
    if (count !== exp_cnt) $display("FAIL bypass_count got %0d want %0d", count, exp_cnt);
    else passed++;
    @(posedge CLK);
    #1;
    byp_sel1 = '0;
    byp_sel2 = '0;
    drain_all(10);
  endtask

  task automatic test_r0();
    logic acc, wen;
    drive_cycle(1, 5'd0, 32'hDEAD, 0, acc, wen);
    checks++;
    if (acc !== 1'b1 || wen !== 1'b0)
      $display("FAIL r0_handshake got accepted=%b wen=%b want 1 0", acc, wen);
    else passed++;
    @(negedge CLK);
    checks++;
    if (count !== 3'd0 || empty !== 1'b1)
      $display("FAIL r0_not_stored got count=%0d empty=%b want 0 1", count, empty);
    else passed++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_coalesce();
    logic acc, wen;
    int   w0 = n_writes;
    int   exp_n;
    drive_cycle(1, 5'd6, 32'd5, 0, acc, wen);
    drive_cycle(1, 5'd6, 32'd9, 0, acc, wen);
`ifdef WBQ_COALESCE_EN
    exp_n = 1;
`else
    exp_n = 2;
`endif
    @(negedge CLK);
    checks++;
    if (int'(count) != exp_n) $display("FAIL coalesce_count got %0d want %0d", count, exp_n);
    else passed++;
    @(posedge CLK);
    #1;
    drain_all(10);
    checks++;
    if ((n_writes - w0) != exp_n)
      $display("FAIL coalesce_writes got %0d want %0d", n_writes - w0, exp_n);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic acc, wen;
    int   w0;
    drive_cycle(1, 5'd1, 32'hA1, 0, acc, wen);
    drive_cycle(1, 5'd2, 32'hA2, 0, acc, wen);
    drive_cycle(1, 5'd3, 32'hA3, 0, acc, wen);
    w0 = n_writes;
    RST = 1'b1;
    wb_if.drain_en = 1'b1;
    @(negedge CLK);
    checks++;
    if (wb_if.rf_wen !== 1'b0) $display("FAIL rst_mid_wen got %b want 0", wb_if.rf_wen);
    else passed++;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_q.delete();
    @(negedge CLK);
    checks++;
    if (empty !== 1'b1 || count !== 3'd0)
      $display("FAIL rst_mid_state got empty=%b count=%0d want 1 0", empty, count);
    else passed++;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 4; k++) drive_cycle(0, '0, '0, 1, acc, wen);
    checks++;
    if (n_writes != w0) $display("FAIL rst_mid_writes got %0d want 0", n_writes - w0);
    else passed++;
  endtask

  initial begin
    wb_if.push_valid = 1'b0;
    wb_if.push_sel   = '0;
    wb_if.push_dat   = '0;
    wb_if.drain_en   = 1'b0;
    test_reset();
    test_order();
    test_full_wrap();
    test_bypass();
    test_r0();
    test_coalesce();
    test_reset_mid();
    checks++;
    if (model_q.size() != 0) $display("FAIL leftover_expected got %0d want 0", model_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
